// File: rtl/tcam_pkg.sv
// tcam_pkg: shared definitions for the ternary CAM routing memory.
//   - Default geometry localparams used by tcam_mem.
//   - Operation codes carried on the MODE input.
//   - Entry struct {data, care, valid} held in the storage array.
//   - entry_match(): ternary match of one entry against a key/enable pair.
package tcam_pkg;

    localparam int TCAM_ID_W   = 4;
    localparam int TCAM_ADDR_W = 4;
    localparam int TCAM_BITS   = 8;
    localparam int TCAM_WORDS  = 16;
    localparam int TCAM_BANKS  = 1;

    localparam logic [2:0] MODE_I   = 3'b000;  // idle
    localparam logic [2:0] MODE_W   = 3'b001;  // write
    localparam logic [2:0] MODE_R   = 3'b010;  // read
    localparam logic [2:0] MODE_F   = 3'b011;  // fire (ID search)
    localparam logic [2:0] MODE_C   = 3'b100;  // compare (full masked key)
    localparam logic [2:0] MODE_RST = 3'b101;  // flush valid bits

    typedef struct packed {
        logic [TCAM_BITS-1:0] data;
        logic [TCAM_BITS-1:0] care;
        logic                 valid;
    } tcam_entry_t;

    // A bit matches when it is a don't-care, its key bit is disabled,
    // or the stored data equals the key; the entry must also be valid.
    function automatic logic entry_match(input tcam_entry_t ent,
                                         input logic [TCAM_BITS-1:0] key,
                                         input logic [TCAM_BITS-1:0] en);
        return ent.valid & (&(~ent.care | ~en | ~(ent.data ^ key)));
    endfunction

endpackage

// File: rtl/tcam_prio_enc.sv
// tcam_prio_enc: lowest-set-bit priority encoder.
//   req   in  Words  request vector
//   idx   out IdxW   index of the lowest set bit (0 when none set)
//   found out 1      at least one request bit is set
module tcam_prio_enc #(
    parameter int Words = 16,
    localparam int IdxW = (Words > 1) ? $clog2(Words) : 1
) (
    input  logic [Words-1:0] req,
    output logic [IdxW-1:0]  idx,
    output logic             found
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx   = {IdxW{1'b0}};
        found = 1'b0;
        for (int i = Words - 1; i >= 0; i--) begin
            idx   = req[i] ? IdxW'(i) : idx;
            found = found | req[i];
        end
    end

endmodule

// File: rtl/tcam_mem.sv
// tcam_mem: ternary CAM routing memory (Words entries of {data, care, valid}).
//   clk, rst_n    clock, async active-low reset
//   MODE          000 idle, 001 write, 010 read, 011 fire, 100 compare,
//                 101 flush, 110/111 idle
//   PacketID_In   fire search key (matched against entry ID field)
//   Data_In       write data / compare key
//   Mskb_In       write bit-enable / compare key-bit enable
//   A_In          entry address for write and read
//   Dcs_In        1 = data word, 0 = care word
//   Vbe_In/Vbi_In valid-bit enable / value
//   DstID_Out     low ID_Width data bits of the lowest matching entry (fire)
//   Data_Out      read word,  Vbo_Out read valid bit
//   Hit_Out       per-bank hit, HitLine_Out per-entry match vector
// All outputs are registered; an output a mode does not drive holds its value.
// The storage struct comes from tcam_pkg, so Bits must equal TCAM_BITS.
module tcam_mem
    import tcam_pkg::*;
#(
    parameter int ID_Width    = TCAM_ID_W,
    parameter int AddressSize = TCAM_ADDR_W,
    parameter int Bits        = TCAM_BITS,
    parameter int Words       = TCAM_WORDS,
    parameter int BankSize    = TCAM_BANKS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [2:0]             MODE,
    input  logic [ID_Width-1:0]    PacketID_In,
    input  logic [Bits-1:0]        Data_In,
    input  logic [Bits-1:0]        Mskb_In,
    input  logic [AddressSize-1:0] A_In,
    input  logic                   Dcs_In,
    input  logic                   Vbe_In,
    input  logic                   Vbi_In,
    output logic [ID_Width-1:0]    DstID_Out,
    output logic [Bits-1:0]        Data_Out,
    output logic                   Vbo_Out,
    output logic [BankSize-1:0]    Hit_Out,
    output logic [Words-1:0]       HitLine_Out
);

    localparam int PerBank = Words / BankSize;
    localparam int IdxW    = (Words > 1) ? $clog2(Words) : 1;

    tcam_entry_t               mem_r [Words];
    logic [Bits-1:0]           key_s;
    logic [Bits-1:0]           en_s;
    logic [Words-1:0]          match_s;
    logic [BankSize-1:0]       bank_hit_s;
    logic [IdxW-1:0]           idx_s;
    logic                      found_s;
    logic [ID_Width-1:0]       dst_sel_s;

    logic [ID_Width-1:0]       dst_r;
    logic [Bits-1:0]           data_out_r;
    logic                      vbo_r;
    logic [BankSize-1:0]       hit_r;
    logic [Words-1:0]          hitline_r;

    // Search key/enable: fire compares only the ID field, compare uses the full key.
    always_comb begin
        key_s = Data_In;
        en_s  = Mskb_In;
        if (MODE == MODE_F) begin
            key_s = {PacketID_In, {(Bits-ID_Width){1'b0}}};
            en_s  = {{ID_Width{1'b1}}, {(Bits-ID_Width){1'b0}}};
        end else begin
            key_s = Data_In;
            en_s  = Mskb_In;
        end
    end

    // Per-entry ternary match lines.
    always_comb begin
        match_s = {Words{1'b0}};
        for (int w = 0; w < Words; w++) begin
            match_s[w] = entry_match(mem_r[w], key_s, en_s);
        end
    end

    // Bank hit: OR of the match lines belonging to each bank.
    always_comb begin
        bank_hit_s = {BankSize{1'b0}};
        for (int b = 0; b < BankSize; b++) begin
            bank_hit_s[b] = |match_s[b*PerBank +: PerBank];
        end
    end

    tcam_prio_enc #(.Words(Words)) u_prio (
        .req   (match_s),
        .idx   (idx_s),
        .found (found_s)
    );

    // Destination ID of the winning entry, zero when nothing matched.
    always_comb begin
        if (found_s) begin
            dst_sel_s = mem_r[idx_s].data[ID_Width-1:0];
        end else begin
            dst_sel_s = {ID_Width{1'b0}};
        end
    end

    // Entry storage: masked writes and flush of the valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < Words; w++) begin
                mem_r[w] <= '{data: {Bits{1'b0}}, care: {Bits{1'b0}}, valid: 1'b0};
            end
        end else begin
            case (MODE)
                MODE_W: begin
                    if (Dcs_In) begin
                        mem_r[A_In].data <= (mem_r[A_In].data & ~Mskb_In) | (Data_In & Mskb_In);
                    end else begin
                        mem_r[A_In].care <= (mem_r[A_In].care & ~Mskb_In) | (Data_In & Mskb_In);
                    end
                    if (Vbe_In) begin
                        mem_r[A_In].valid <= Vbi_In;
                    end
                end
                MODE_RST: begin
                    for (int w = 0; w < Words; w++) begin
                        mem_r[w].valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers: each mode updates only the outputs it owns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dst_r      <= {ID_Width{1'b0}};
            data_out_r <= {Bits{1'b0}};
            vbo_r      <= 1'b0;
            hit_r      <= {BankSize{1'b0}};
            hitline_r  <= {Words{1'b0}};
        end else begin
            case (MODE)
                MODE_R: begin
                    data_out_r <= Dcs_In ? mem_r[A_In].data : mem_r[A_In].care;
                    vbo_r      <= Vbe_In & mem_r[A_In].valid;
                end
                MODE_F: begin
                    hitline_r <= match_s;
                    hit_r     <= bank_hit_s;
                    dst_r     <= dst_sel_s;
                end
                MODE_C: begin
                    hitline_r <= match_s;
                    hit_r     <= bank_hit_s;
                    dst_r     <= {ID_Width{1'b0}};
                end
                MODE_RST: begin
                    dst_r      <= {ID_Width{1'b0}};
                    data_out_r <= {Bits{1'b0}};
                    vbo_r      <= 1'b0;
                    hit_r      <= {BankSize{1'b0}};
                    hitline_r  <= {Words{1'b0}};
                end
                default: begin
                end
            endcase
        end
    end

    assign DstID_Out   = dst_r;
    assign Data_Out    = data_out_r;
    assign Vbo_Out     = vbo_r;
    assign Hit_Out     = hit_r;
    assign HitLine_Out = hitline_r;

endmodule

// File: tb/tb_tcam_mem.sv
// tb_tcam_mem: table-driven directed test of tcam_mem plus hand-written
// reset sequences. Each table row is one operation and the full expected
// output state after it.
module tb_tcam_mem;

    logic        clk;
    logic        rst_n;
    logic [2:0]  mode;
    logic [3:0]  pid;
    logic [7:0]  din;
    logic [7:0]  msk;
    logic [3:0]  addr;
    logic        dcs;
    logic        vbe;
    logic        vbi;
    logic [3:0]  dst;
    logic [7:0]  dout;
    logic        vbo;
    logic [0:0]  hit;
    logic [15:0] hitline;

    int checks   = 0;
    int failures = 0;

    tcam_mem dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .MODE        (mode),
        .PacketID_In (pid),
        .Data_In     (din),
        .Mskb_In     (msk),
        .A_In        (addr),
        .Dcs_In      (dcs),
        .Vbe_In      (vbe),
        .Vbi_In      (vbi),
        .DstID_Out   (dst),
        .Data_Out    (dout),
        .Vbo_Out     (vbo),
        .Hit_Out     (hit),
        .HitLine_Out (hitline)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  mode;
        logic [3:0]  pid;
        logic [7:0]  din;
        logic [7:0]  msk;
        logic [3:0]  addr;
        logic        dcs;
        logic        vbe;
        logic        vbi;
        logic [3:0]  e_dst;
        logic [7:0]  e_dout;
        logic        e_vbo;
        logic        e_hit;
        logic [15:0] e_hl;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int row, input logic [3:0] e_dst,
                           input logic [7:0] e_dout, input logic e_vbo,
                           input logic e_hit, input logic [15:0] e_hl);
        chk({tag, "_dst"},     row, 32'(dst),     32'(e_dst));
        chk({tag, "_dout"},    row, 32'(dout),    32'(e_dout));
        chk({tag, "_vbo"},     row, 32'(vbo),     32'(e_vbo));
        chk({tag, "_hit"},     row, 32'(hit),     32'(e_hit));
        chk({tag, "_hitline"}, row, 32'(hitline), 32'(e_hl));
    endtask

    task automatic drive(input logic [2:0] m, input logic [3:0] p, input logic [7:0] d,
                         input logic [7:0] k, input logic [3:0] a, input logic c,
                         input logic e, input logic v);
        mode = m; pid = p; din = d; msk = k; addr = a; dcs = c; vbe = e; vbi = v;
    endtask

    task automatic add(input logic [2:0] m, input logic [3:0] p, input logic [7:0] d,
                       input logic [7:0] k, input logic [3:0] a, input logic c,
                       input logic e, input logic v, input logic [3:0] xd,
                       input logic [7:0] xo, input logic xv, input logic xh,
                       input logic [15:0] xl);
        vec_t r;
        r.mode = m; r.pid = p; r.din = d; r.msk = k; r.addr = a;
        r.dcs = c; r.vbe = e; r.vbi = v;
        r.e_dst = xd; r.e_dout = xo; r.e_vbo = xv; r.e_hit = xh; r.e_hl = xl;
        vecs.push_back(r);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(3'b000, 4'h0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);

        //   mode    pid   din    msk    a     dcs   vbe   vbi   dst   dout   vbo   hit   hitline
        add(3'b001, 4'h0, 8'h00, 8'hFF, 4'h1, 1'b1, 1'b1, 1'b1, 4'h0, 8'h00, 1'b0, 1'b0, 16'h0000); // 0 write data A1 valid
        add(3'b010, 4'h0, 8'h00, 8'h00, 4'h1, 1'b1, 1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 16'h0000); // 1 read A1
        add(3'b101, 4'h0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 16'h0000); // 2 flush
        add(3'b001, 4'h0, 8'h5A, 8'hFF, 4'h3, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 16'h0000); // 3 data 5A @3
        add(3'b001, 4'h0, 8'hFF, 8'hFF, 4'h3, 1'b0, 1'b1, 1'b1, 4'h0, 8'h00, 1'b0, 1'b0, 16'h0000); // 4 care FF @3 valid
        add(3'b100, 4'h0, 8'h5A, 8'hFF, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 16'h0008); // 5 compare 5A
        add(3'b100, 4'h0, 8'h5B, 8'hFF, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 16'h0000); // 6 compare 5B miss
        add(3'b100, 4'h0, 8'h5B, 8'hFE, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 16'h0008); // 7 bit0 disabled
        add(3'b010, 4'h0, 8'h00, 8'h00, 4'h3, 1'b0, 1'b1, 1'b0, 4'h0, 8'hFF, 1'b1, 1'b1, 16'h0008); // 8 read care @3
        add(3'b000, 4'hF, 8'hA5, 8'hFF, 4'h7, 1'b1, 1'b1, 1'b1, 4'h0, 8'hFF, 1'b1, 1'b1, 16'h0008); // 9 idle holds
        add(3'b111, 4'h3, 8'h37, 8'hFF, 4'h2, 1'b1, 1'b1, 1'b1, 4'h0, 8'hFF, 1'b1, 1'b1, 16'h0008); // 10 mode 111 holds
        add(3'b101, 4'h0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 16'h0000); // 11 flush
        add(3'b001, 4'h0, 8'h37, 8'hFF, 4'h2, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 16'h0000); // 12
        add(3'b001, 4'h0, 8'hF0, 8'hFF, 4'h2, 1'b0, 1'b1, 1'b1, 4'h0, 8'h00, 1'b0, 1'b0, 16'h0000); // 13
        add(3'b001, 4'h0, 8'h3C, 8'hFF, 4'h5, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 16'h0000); // 14
        add(3'b001, 4'h0, 8'hF0, 8'hFF, 4'h5, 1'b0, 1'b1, 1'b1, 4'h0, 8'h00, 1'b0, 1'b0, 16'h0000); // 15
        add(3'b011, 4'h3, 8'hFF, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 4'h7, 8'h00, 1'b0, 1'b1, 16'h0024); // 16 fire 3, entry 2 wins
        add(3'b011, 4'h5, 8'hFF, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 16'h0000); // 17 fire 5, entry 3 invalid
        add(3'b001, 4'h0, 8'h00, 8'h00, 4'h3, 1'b1, 1'b1, 1'b1, 4'h0, 8'h00, 1'b0, 1'b0, 16'h0000); // 18 set valid only
        add(3'b011, 4'h5, 8'hFF, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 4'hA, 8'h00, 1'b0, 1'b1, 16'h0008); // 19 fire 5
        add(3'b100, 4'h0, 8'h3C, 8'hFF, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 16'h0024); // 20 compare zeroes dst
        add(3'b011, 4'h3, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 4'h7, 8'h00, 1'b0, 1'b1, 16'h0024); // 21 fire 3
        add(3'b010, 4'h0, 8'h00, 8'h00, 4'h5, 1'b1, 1'b0, 1'b0, 4'h7, 8'h3C, 1'b0, 1'b1, 16'h0024); // 22 read, Vbe=0
        add(3'b001, 4'h0, 8'hFF, 8'hFF, 4'h4, 1'b1, 1'b0, 1'b0, 4'h7, 8'h3C, 1'b0, 1'b1, 16'h0024); // 23
        add(3'b001, 4'h0, 8'h00, 8'h0F, 4'h4, 1'b1, 1'b0, 1'b0, 4'h7, 8'h3C, 1'b0, 1'b1, 16'h0024); // 24 partial write
        add(3'b010, 4'h0, 8'h00, 8'h00, 4'h4, 1'b1, 1'b1, 1'b0, 4'h7, 8'hF0, 1'b0, 1'b1, 16'h0024); // 25 read F0
        add(3'b101, 4'h0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 16'h0000); // 26 flush
        add(3'b011, 4'h3, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 16'h0000); // 27 fire after flush
        add(3'b010, 4'h0, 8'h00, 8'h00, 4'h2, 1'b1, 1'b1, 1'b0, 4'h0, 8'h37, 1'b0, 1'b0, 16'h0000); // 28 data retained
        add(3'b010, 4'h0, 8'h00, 8'h00, 4'h2, 1'b0, 1'b1, 1'b0, 4'h0, 8'hF0, 1'b0, 1'b0, 16'h0000); // 29 care retained
        add(3'b001, 4'h0, 8'h3E, 8'hFF, 4'hF, 1'b1, 1'b0, 1'b0, 4'h0, 8'hF0, 1'b0, 1'b0, 16'h0000); // 30
        add(3'b001, 4'h0, 8'hF0, 8'hFF, 4'hF, 1'b0, 1'b1, 1'b1, 4'h0, 8'hF0, 1'b0, 1'b0, 16'h0000); // 31
        add(3'b001, 4'h0, 8'h31, 8'hFF, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 8'hF0, 1'b0, 1'b0, 16'h0000); // 32
        add(3'b001, 4'h0, 8'hF0, 8'hFF, 4'h0, 1'b0, 1'b1, 1'b1, 4'h0, 8'hF0, 1'b0, 1'b0, 16'h0000); // 33
        add(3'b011, 4'h3, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 4'h1, 8'hF0, 1'b0, 1'b1, 16'h8001); // 34 entries 0 and 15
        add(3'b001, 4'h0, 8'h00, 8'h00, 4'h0, 1'b1, 1'b1, 1'b0, 4'h1, 8'hF0, 1'b0, 1'b1, 16'h8001); // 35 invalidate 0
        add(3'b011, 4'h3, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 4'hE, 8'hF0, 1'b0, 1'b1, 16'h8000); // 36 entry 15 wins

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", -1, 4'h0, 8'h00, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: drive on the falling edge, check just after the rising edge.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].mode, vecs[i].pid, vecs[i].din, vecs[i].msk,
                  vecs[i].addr, vecs[i].dcs, vecs[i].vbe, vecs[i].vbi);
            @(posedge clk);
            #1;
            chk_all("vec", i, vecs[i].e_dst, vecs[i].e_dout, vecs[i].e_vbo,
                    vecs[i].e_hit, vecs[i].e_hl);
        end

        // Async reset in the middle of a write: outputs clear without a clock edge.
        @(negedge clk);
        drive(3'b001, 4'h0, 8'h55, 8'hFF, 4'hF, 1'b1, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 100, 4'h0, 8'h00, 1'b0, 1'b0, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Storage was cleared: reads return zero with valid low.
        drive(3'b010, 4'h0, 8'h00, 8'h00, 4'hF, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk_all("post_rst_rd15", 101, 4'h0, 8'h00, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        drive(3'b010, 4'h0, 8'h00, 8'h00, 4'h2, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk_all("post_rst_rd2", 102, 4'h0, 8'h00, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        drive(3'b010, 4'h0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk_all("post_rst_care0", 103, 4'h0, 8'h00, 1'b0, 1'b0, 16'h0000);
        // Fire that would hit entry 15 before reset finds nothing now.
        @(negedge clk);
        drive(3'b011, 4'h3, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk_all("post_rst_fire", 104, 4'h0, 8'h00, 1'b0, 1'b0, 16'h0000);

        @(negedge clk);
        drive(3'b000, 4'h0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
